cordic_client: RTL and testbench

Host-side initiator for the CORDIC core. It accepts rotation/vectoring requests over a valid/ready handshake, packs them into the core's 49-bit input word, and drives the core's valid-only input. It collects the core's 49-bit results into a response FIFO and returns them to the host over valid/ready, in order. Issue is credit-limited so the core, which has no backpressure, can never overflow the FIFO. Sits between host logic and `cordic_top`.

---
 rtl/cordic_pkg.sv | 24 ++
 rtl/cordic_rsp_fifo.sv | 43 ++++
 rtl/cordic_client.sv | 60 ++++++
 tb/tb_cordic_client.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared widths, field layout, mode encodings and request packing for the CORDIC client
package cordic_pkg;
  localparam int TOTAL_WIDTH = 49;
  localparam int FIELD_WIDTH = 16;
  localparam int MODE_BIT = 48;
  localparam int X_LSB = 32;
  localparam int Y_LSB = 16;
  localparam int Z_LSB = 0;
  typedef enum logic {MODE_ROT = 1'b0, MODE_VEC = 1'b1} cordic_mode_e;
  function automatic logic [TOTAL_WIDTH-1:0] pack_req(
    input logic mode,
    input logic [FIELD_WIDTH-1:0] x,
    input logic [FIELD_WIDTH-1:0] y,
    input logic [FIELD_WIDTH-1:0] z
  );
    logic [TOTAL_WIDTH-1:0] w;
    w = '0;
    w[MODE_BIT] = mode;
    w[X_LSB +: FIELD_WIDTH] = x;
    w[Y_LSB +: FIELD_WIDTH] = y;
    w[Z_LSB +: FIELD_WIDTH] = z;
    return w;
  endfunction
endpackage

// File: rtl/cordic_rsp_fifo.sv
// cordic_rsp_fifo: first-word-fall-through response FIFO with full/empty and an overflow pulse
module cordic_rsp_fifo
  import cordic_pkg::*;
#(
  parameter int WIDTH = TOTAL_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  always_comb begin
    o_empty = wr_ptr == rd_ptr;
    o_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop = i_pop && !o_empty;
    do_push = i_push && (!o_full || do_pop);
    o_ovf = i_push && o_full && !do_pop;
    o_data = mem[rd_ptr[AW-1:0]];
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop) rd_ptr <= rd_ptr + ONE;
    end
  end
  always_ff @(posedge i_clk) begin
    if (do_push && !i_rst) mem[wr_ptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/cordic_client.sv
// cordic_client: credit-limited host initiator that issues requests to the CORDIC core and returns its results in order
module cordic_client
  import cordic_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_vld,
  output logic                   o_req_rdy,
  input  logic                   i_req_mode,
  input  logic [FIELD_WIDTH-1:0] i_req_x,
  input  logic [FIELD_WIDTH-1:0] i_req_y,
  input  logic [FIELD_WIDTH-1:0] i_req_z,
  output logic                   o_core_vld,
  output logic [TOTAL_WIDTH-1:0] o_core_data,
  input  logic                   i_core_vld,
  input  logic [TOTAL_WIDTH-1:0] i_core_data,
  output logic                   o_rsp_vld,
  input  logic                   i_rsp_rdy,
  output logic [TOTAL_WIDTH-1:0] o_rsp_data,
  output logic                   o_busy,
  output logic                   o_ovf
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CRED = CW'(FIFO_DEPTH);
  logic [CW-1:0] cred;
  logic accept, pop, empty, full, ovf_pulse;
  always_comb begin
    o_req_rdy = cred != '0;
    accept = i_req_vld && o_req_rdy;
    pop = o_rsp_vld && i_rsp_rdy;
    o_busy = cred != FULL_CRED;
    o_rsp_vld = !empty;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cred <= FULL_CRED;
      o_core_vld <= 1'b0;
      o_core_data <= '0;
      o_ovf <= 1'b0;
    end else begin
      cred <= cred - CW'(accept) + CW'(pop);
      o_core_vld <= accept;
      if (accept) o_core_data <= pack_req(i_req_mode, i_req_x, i_req_y, i_req_z);
      if (ovf_pulse && full) o_ovf <= 1'b1;
    end
  end
  cordic_rsp_fifo #(.WIDTH(TOTAL_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (i_core_vld),
    .i_data (i_core_data),
    .i_pop  (pop),
    .o_data (o_rsp_data),
    .o_full (full),
    .o_empty(empty),
    .o_ovf  (ovf_pulse)
  );
endmodule

// File: tb/tb_cordic_client.sv
// tb_cordic_client: scoreboard bench for cordic_client with a fixed-latency behavioural core
module tb_cordic_client;
  localparam int L = 4;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_req_vld = 1'b0, i_req_mode = 1'b0, i_rsp_rdy = 1'b0;
  logic [15:0] i_req_x = '0, i_req_y = '0, i_req_z = '0;
  logic o_req_rdy, o_core_vld, o_rsp_vld, o_busy, o_ovf, i_core_vld;
  logic [48:0] o_core_data, i_core_data, o_rsp_data;
  logic force_en = 1'b0, force_vld = 1'b0;
  logic [48:0] force_data = '0;
  logic [L-1:0] pv;
  logic [48:0] pd [L];
  logic [48:0] exp_q [$];
  int n_chk = 0, n_fail = 0, n_rsp = 0;
  always #5 i_clk = ~i_clk;
  cordic_client #(.FIFO_DEPTH(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy),
    .i_req_mode(i_req_mode), .i_req_x(i_req_x), .i_req_y(i_req_y), .i_req_z(i_req_z),
    .o_core_vld(o_core_vld), .o_core_data(o_core_data), .i_core_vld(i_core_vld),
    .i_core_data(i_core_data), .o_rsp_vld(o_rsp_vld), .i_rsp_rdy(i_rsp_rdy),
    .o_rsp_data(o_rsp_data), .o_busy(o_busy), .o_ovf(o_ovf)
  );
  function automatic logic [48:0] core_f(input logic [48:0] d);
    return {d[48], d[47:32] + d[31:16], d[31:16] - d[47:32], ~d[15:0]};
  endfunction
  always_ff @(posedge i_clk) begin
    if (i_rst) pv <= '0;
    else pv <= {pv[L-2:0], o_core_vld};
    pd[0] <= core_f(o_core_data);
    for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
  end
  assign i_core_vld = force_en ? force_vld : pv[L-1];
  assign i_core_data = force_en ? force_data : pd[L-1];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    if (i_req_vld && o_req_rdy) exp_q.push_back(core_f({i_req_mode, i_req_x, i_req_y, i_req_z}));
    if (o_rsp_vld && i_rsp_rdy) begin
      n_rsp++;
      if (exp_q.size() == 0) check("extra_rsp", 64'd1, 64'd0);
      else check("rsp_data", o_rsp_data, exp_q.pop_front());
    end
    @(posedge i_clk);
    #1;
  endtask
  task automatic do_reset(input int n);
    i_req_vld = 1'b0;
    i_rsp_rdy = 1'b0;
    i_rst = 1'b1;
    repeat (n) tick();
    i_rst = 1'b0;
    exp_q.delete();
  endtask
  task automatic rand_req();
    i_req_mode = 1'($urandom_range(0, 1));
    i_req_x = 16'($urandom);
    i_req_y = 16'($urandom);
    i_req_z = 16'($urandom);
  endtask
  initial begin
    int sent, cyc, base, stale;
    do_reset(3);
    check("rst_req_rdy", o_req_rdy, 1);
    check("rst_core_vld", o_core_vld, 0);
    check("rst_core_data", o_core_data, 0);
    check("rst_rsp_vld", o_rsp_vld, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ovf", o_ovf, 0);
    i_req_vld = 1'b1;
    i_req_mode = 1'b0;
    i_req_x = 16'h1234;
    i_req_y = 16'h0000;
    i_req_z = 16'h2000;
    tick();
    i_req_vld = 1'b0;
    check("pack_vld", o_core_vld, 1);
    check("pack_data", o_core_data, 49'h0_1234_0000_2000);
    check("pack_busy", o_busy, 1);
    tick();
    check("idle_vld", o_core_vld, 0);
    check("hold_data", o_core_data, 49'h0_1234_0000_2000);
    i_rsp_rdy = 1'b1;
    cyc = 0;
    while ((exp_q.size() != 0 || o_rsp_vld) && cyc < 50) begin
      tick();
      cyc++;
    end
    check("pack_drained", 64'(exp_q.size()), 0);
    check("pack_idle_busy", o_busy, 0);
    i_rsp_rdy = 1'b0;
    i_req_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_req();
      tick();
    end
    check("cred0_rdy", o_req_rdy, 0);
    check("cred0_busy", o_busy, 1);
    repeat (2) tick();
    check("cred0_hold_rdy", o_req_rdy, 0);
    i_req_vld = 1'b0;
    repeat (8) tick();
    check("fill_rsp_vld", o_rsp_vld, 1);
    check("fill_q", 64'(exp_q.size()), 8);
    i_rsp_rdy = 1'b1;
    tick();
    i_rsp_rdy = 1'b0;
    check("pop_rdy", o_req_rdy, 1);
    i_req_vld = 1'b1;
    rand_req();
    tick();
    i_req_vld = 1'b0;
    check("refill_rdy", o_req_rdy, 0);
    repeat (8) tick();
    force_en = 1'b1;
    force_vld = 1'b1;
    force_data = 49'h1_aaaa_5555_0f0f;
    exp_q.push_back(force_data);
    i_rsp_rdy = 1'b1;
    tick();
    check("full_pushpop_ovf", o_ovf, 0);
    check("full_pushpop_rdy", o_req_rdy, 1);
    force_data = 49'h0_dead_beef_cafe;
    i_rsp_rdy = 1'b0;
    tick();
    force_en = 1'b0;
    check("drop_ovf", o_ovf, 1);
    i_rsp_rdy = 1'b1;
    repeat (12) tick();
    check("drop_drained", 64'(exp_q.size()), 0);
    check("drop_rsp_vld", o_rsp_vld, 0);
    check("ovf_sticky", o_ovf, 1);
    force_en = 1'b1;
    force_data = 49'h1_1111_2222_3333;
    i_rst = 1'b1;
    repeat (2) tick();
    force_en = 1'b0;
    do_reset(1);
    check("ovf_cleared", o_ovf, 0);
    check("rst_ignore_core", o_rsp_vld, 0);
    check("rst2_busy", o_busy, 0);
    sent = 0;
    cyc = 0;
    base = n_rsp;
    while ((sent < 20 || exp_q.size() != 0) && cyc < 1000) begin
      i_req_vld = sent < 20 && $urandom_range(0, 3) != 0;
      rand_req();
      i_rsp_rdy = 1'($urandom_range(0, 1));
      if (i_req_vld && o_req_rdy) sent++;
      tick();
      cyc++;
    end
    i_req_vld = 1'b0;
    i_rsp_rdy = 1'b0;
    check("order_sent", 64'(sent), 20);
    check("order_count", 64'(n_rsp - base), 20);
    check("order_ovf", o_ovf, 0);
    check("order_busy", o_busy, 0);
    i_req_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_req();
      tick();
    end
    i_req_vld = 1'b0;
    repeat (2) tick();
    check("mid_busy", o_busy, 1);
    do_reset(1);
    check("mid_rdy", o_req_rdy, 1);
    check("mid_busy_after", o_busy, 0);
    check("mid_rsp_vld", o_rsp_vld, 0);
    i_rsp_rdy = 1'b1;
    stale = 0;
    repeat (12) begin
      if (o_rsp_vld) stale++;
      tick();
    end
    check("mid_no_stale", 64'(stale), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
